// File: rtl/memory_stage_pkg.sv
// Shared constants for the memory stage: opcodes, access width codes, bubble instruction, FSM states.
package memory_stage_pkg;

    localparam logic [6:0]  OP_LCC       = 7'b0000011;
    localparam logic [6:0]  OP_SCC       = 7'b0100011;

    localparam logic [1:0]  W_BYTE       = 2'b00;
    localparam logic [1:0]  W_HALF       = 2'b01;
    localparam logic [1:0]  W_WORD       = 2'b10;

    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/ready bus between the memory stage (master) and data memory (slave).
interface memory_stage_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (output req, we, addr, be, wdata, input rdata, ready);
    modport slave  (input req, we, addr, be, wdata, output rdata, ready);

endinterface

// File: rtl/memory_stage_load_store_align.sv
// Combinational byte-lane logic: store enables/replication, load lane extraction/extension, misalign detect.
module load_store_align
    import memory_stage_pkg::*;
(
    input  logic        is_mem,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        misalign = is_mem && ((funct3[1:0] == W_HALF && addr_lo[0]) ||
                              (funct3[1:0] == W_WORD && addr_lo != 2'b00));

        case (funct3[1:0])
            W_BYTE: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{rs2[7:0]}};
            end
            W_HALF: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{rs2[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = rs2;
            end
        endcase

        // Halfword loads are only ever used aligned, so the upper/lower half is picked by addr_lo[1].
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'h0, byte_sel};
            3'b101:  load_data = {16'h0, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: X/M register, data-memory handshake FSM with timeout, M/W register and bypass taps.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int          WAIT_TIMEOUT = 255,
    parameter logic [31:0] NOP_INST     = NOP_INST_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          PC_x,
    input  logic [31:0]          inst_x,
    input  logic [31:0]          alu_x,
    input  logic [31:0]          rs2_x,
    memory_stage_if.master       dmem,
    output logic                 stall_m,
    output logic                 misalign_m,
    output logic [31:0]          alu_m,
    output logic [31:0]          PC_w,
    output logic [31:0]          inst_w,
    output logic [31:0]          alu_w,
    output logic [31:0]          load_w,
    output logic [31:0]          wb_data_w,
    output logic                 bus_err_w
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(WAIT_TIMEOUT - 1);

    logic [31:0] PC_m, inst_m, rs2_m;
    logic        is_load_m, is_store_m, mem_op, timeout_abort;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_data;
    mem_state_t  state, state_n;
    logic [7:0]  wait_cnt, wait_cnt_n;

    assign is_load_m  = inst_m[6:0] == OP_LCC;
    assign is_store_m = inst_m[6:0] == OP_SCC;
    assign mem_op     = (is_load_m || is_store_m) && !misalign_m;

    // X/M register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC_m   <= '0;
            inst_m <= NOP_INST;
            alu_m  <= '0;
            rs2_m  <= '0;
        end else if (!stall_m) begin
            PC_m   <= PC_x;
            inst_m <= inst_x;
            alu_m  <= alu_x;
            rs2_m  <= rs2_x;
        end
    end

    load_store_align u_align (
        .is_mem    (is_load_m || is_store_m),
        .funct3    (inst_m[14:12]),
        .addr_lo   (alu_m[1:0]),
        .rs2       (rs2_m),
        .rdata     (dmem.rdata),
        .be        (st_be),
        .wdata     (st_wdata),
        .load_data (ld_data),
        .misalign  (misalign_m)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
        end
    end

    // wait_cnt counts request cycles already spent without ready, including the first IDLE one.
    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        case (state)
            ST_IDLE: begin
                if (mem_op && !dmem.ready) begin
                    state_n    = ST_WAIT;
                    wait_cnt_n = 8'd1;
                end
            end
            ST_WAIT: begin
                if (dmem.ready || wait_cnt == TIMEOUT_LAST) begin
                    state_n    = ST_IDLE;
                    wait_cnt_n = '0;
                end else begin
                    wait_cnt_n = wait_cnt + 8'd1;
                end
            end
            default: begin
                state_n    = ST_IDLE;
                wait_cnt_n = '0;
            end
        endcase
    end

    // Request and stall are gated by rst so an in-flight access is dropped the instant reset asserts.
    always_comb begin
        timeout_abort = (state == ST_WAIT) && !dmem.ready && (wait_cnt == TIMEOUT_LAST);
        dmem.req      = mem_op && !rst;
        dmem.we       = is_store_m;
        dmem.addr     = {alu_m[31:2], 2'b00};
        dmem.be       = is_store_m ? st_be : 4'b1111;
        dmem.wdata    = st_wdata;
        stall_m       = mem_op && !dmem.ready && !timeout_abort && !rst;
    end

    // M/W register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC_w      <= '0;
            inst_w    <= NOP_INST;
            alu_w     <= '0;
            load_w    <= '0;
            bus_err_w <= 1'b0;
        end else if (stall_m || misalign_m) begin
            PC_w      <= '0;
            inst_w    <= NOP_INST;
            alu_w     <= '0;
            load_w    <= '0;
            bus_err_w <= 1'b0;
        end else begin
            PC_w      <= PC_m;
            inst_w    <= inst_m;
            alu_w     <= alu_m;
            load_w    <= (is_load_m && dmem.ready) ? ld_data : '0;
            bus_err_w <= timeout_abort;
        end
    end

    assign wb_data_w = (inst_w[6:0] == OP_LCC) ? load_w : alu_w;

endmodule
